seg_scan_ctrl: RTL

- Time-multiplexed scan controller for the 4-digit seven-segment display on the slot-machine board.
- Selects one digit per slot and presents its 4-bit code on `number` for the shared hex-to-segment decoder (active-low segments, DP off). Drives the matching active-low anode.
- Adds inter-digit blanking against ghosting, per-digit blank and blink control, and a frame-synchronous shadow load so game logic never tears a displayed value.

---
 rtl/seg_scan_if.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 87 ++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Display-side bundle between the game logic and the seven-segment scan controller.
// The master drives the digit value, the load strobe and the masks; the slave returns the scan outputs.
interface seg_scan_if;
   logic [15:0] digits;
   logic        load;
   logic [3:0]  blank_mask;
   logic [3:0]  blink_mask;
   logic [3:0]  number;
   logic [3:0]  an;
   logic        frame_done;
   logic        load_pending;

   modport master (
      output digits, load, blank_mask, blink_mask,
      input  number, an, frame_done, load_pending
   );

   modport slave (
      input  digits, load, blank_mask, blink_mask,
      output number, an, frame_done, load_pending
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with inter-digit blanking, per-digit blank/blink and frame-synchronous shadow load.
// Latency: outputs registered, 1 cycle behind counter state. No backpressure: load is a one-shot strobe, always accepted.
module seg_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_DIV    = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   seg_scan_if.slave  bus
);

   localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [SW-1:0] slot_cnt;
   logic [1:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic [15:0]   active;
   logic [15:0]   pending;
   logic          load_pending;

   logic          slot_wrap;
   logic          blink_wrap;
   logic          boundary;
   logic          dark;
   logic [3:0]    number_next;
   logic [3:0]    an_next;

   always_comb begin
      slot_wrap   = (slot_cnt == SW'(REFRESH_DIV - 1));
      blink_wrap  = (blink_cnt == BW'(BLINK_DIV - 1));
      boundary    = slot_wrap && (idx == 2'd3);
      // Signed compare keeps BLANK_CYCLES = 0 a clean "never blank".
      dark        = (int'(slot_cnt) < BLANK_CYCLES)
                    || bus.blank_mask[idx]
                    || (bus.blink_mask[idx] && blink_phase);
      number_next = 4'h0;
      case (idx)
         2'd0: number_next = active[3:0];
         2'd1: number_next = active[7:4];
         2'd2: number_next = active[11:8];
         2'd3: number_next = active[15:12];
         default: number_next = 4'h0;
      endcase
      an_next = dark ? 4'b1111 : ~(4'b0001 << idx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt     <= '0;
         idx          <= 2'd0;
         blink_cnt    <= '0;
         blink_phase  <= 1'b0;
         active       <= 16'h0000;
         pending      <= 16'h0000;
         load_pending <= 1'b0;
         bus.number     <= 4'h0;
         bus.an         <= 4'b1111;
         bus.frame_done <= 1'b0;
      end else begin
         slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
         if (slot_wrap) idx <= idx + 2'd1;

         blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
         if (blink_wrap) blink_phase <= ~blink_phase;

         // A load landing on the boundary bypasses pending so the newest value wins.
         if (boundary) begin
            if (bus.load)          active <= bus.digits;
            else if (load_pending) active <= pending;
            load_pending <= 1'b0;
         end else if (bus.load) begin
            pending      <= bus.digits;
            load_pending <= 1'b1;
         end

         bus.number     <= number_next;
         bus.an         <= an_next;
         bus.frame_done <= boundary;
      end
   end

   assign bus.load_pending = load_pending;

endmodule
